// File: rtl/avalon_sink_pkg.sv
// Shared types and constants for the Avalon-ST packet sink.
// Framing states, backpressure modes and LFSR parameters.
package avalon_sink_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    BP_ALWAYS   = 2'd0,
    BP_PERIODIC = 2'd1,
    BP_LFSR     = 2'd2,
    BP_NEVER    = 2'd3
  } bp_mode_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting register sit at bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/avalon_bp_gen.sv
// Free-running ready generator for the packet sink.
// Periodic counter and 16-bit Fibonacci LFSR, decoded by mode.
module avalon_bp_gen
  import avalon_sink_pkg::*;
#(
  parameter int BP_PERIOD = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bp_mode,
  output logic       ready
);

  localparam int CW = (BP_PERIOD > 2) ? $clog2(BP_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BP_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  always_comb begin
    ready = 1'b1;
    unique case (bp_mode_t'(bp_mode))
      BP_ALWAYS:   ready = 1'b1;
      BP_PERIODIC: ready = (cnt != LAST);
      BP_LFSR:     ready = |lfsr[1:0];
      BP_NEVER:    ready = 1'b0;
      default:     ready = 1'b1;
    endcase
  end

endmodule

// File: rtl/avalon_st_packet_sink.sv
// Avalon-ST packet sink: framing FSM, capture bank and error flags.
// Ready backpressure comes from avalon_bp_gen.
module avalon_st_packet_sink
  import avalon_sink_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int EMPTY_WIDTH = $clog2(WIDTH/8),
  parameter int DEPTH       = 4,
  parameter int BP_PERIOD   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             data,
  input  logic                         valid,
  output logic                         ready,
  input  logic                         sop,
  input  logic                         eop,
  input  logic [EMPTY_WIDTH-1:0]       empty,
  input  logic [1:0]                   bp_mode,
  input  logic                         clr,
  output logic [DEPTH-1:0][WIDTH-1:0]  reg_out,
  output logic                         pkt_valid,
  output logic                         pkt_done,
  output logic [15:0]                  beat_count,
  output logic [31:0]                  byte_count,
  output logic [15:0]                  pkt_count,
  output logic                         err_sop,
  output logic                         err_orphan,
  output logic                         overflow
);

  state_t      state, state_d;
  logic        accept;
  logic        start, append, orphan, finish;
  logic [15:0] beats_d;

  avalon_bp_gen #(.BP_PERIOD(BP_PERIOD)) u_bp (
    .clk     (clk),
    .rst     (rst),
    .bp_mode (bp_mode),
    .ready   (ready)
  );

  assign accept = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    start   = accept && sop;
    append  = accept && !sop && (state == BUSY);
    orphan  = accept && !sop && (state == IDLE);
    finish  = (start || append) && eop;
    beats_d = (beat_count == 16'hFFFF) ? beat_count
                                       : beat_count + 16'd1;
    if (start) beats_d = 16'd1;
    if (start)  state_d = BUSY;
    if (finish) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_out    <= '0;
      pkt_valid  <= 1'b0;
      pkt_done   <= 1'b0;
      beat_count <= '0;
      byte_count <= '0;
      pkt_count  <= '0;
      err_sop    <= 1'b0;
      err_orphan <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pkt_done <= finish;
      if (clr) begin
        err_sop    <= 1'b0;
        err_orphan <= 1'b0;
        overflow   <= 1'b0;
        pkt_count  <= '0;
      end
      if (start) begin
        reg_out    <= '0;
        reg_out[0] <= data;
        pkt_valid  <= 1'b0;
        if (state == BUSY) err_sop <= 1'b1;
      end
      if (append) begin
        if (beat_count < 16'(DEPTH)) begin
          for (int i = 0; i < DEPTH; i++)
            if (beat_count == 16'(i)) reg_out[i] <= data;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (start || append) beat_count <= beats_d;
      if (orphan) err_orphan <= 1'b1;
      // Beat's own count update overrides a simultaneous clr.
      if (finish) begin
        byte_count <= 32'(beats_d) * 32'(WIDTH/8) - 32'(empty);
        pkt_valid  <= 1'b1;
        pkt_count  <= pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/avalon_st_packet_sink.md
# avalon_st_packet_sink

Parametrised Avalon-ST packet sink that terminates a stream in the test environment, capturing each packet's first DEPTH beats into a register bank and reporting packet length, byte count and protocol errors. It generates its own `ready` backpressure from a selectable pattern (always-ready, periodic, pseudo-random), so upstream sources can be exercised under stall conditions. It is the packet-aware, framing-checked successor to the fixed four-word capture sink.

## Interface
- `WIDTH`, 64: data bus width in bits; must be a multiple of 8.
- `EMPTY_WIDTH`, `$clog2(WIDTH/8)`: width of `empty`.
- `DEPTH`, 4: beats captured per packet; must be ≥1.
- `BP_PERIOD`, 5: period of periodic backpressure; must be ≥2.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  WIDTH  stream data.
- `valid`  in  1  source beat valid.
- `ready`  out  1  sink ready; a beat transfers when `valid && ready`.
- `sop`  in  1  start of packet, qualified by valid.
- `eop`  in  1  end of packet, qualified by valid.
- `empty`  in  EMPTY_WIDTH  unused bytes in the eop beat; ignored on non-eop beats.
- `bp_mode`  in  2  0 = always ready, 1 = periodic, 2 = LFSR, 3 = never ready.
- `clr`  in  1  clears sticky error flags and `pkt_count`.
- `reg_out`  out  [DEPTH][WIDTH]  captured beats; index 0 is the sop beat.
- `pkt_valid`  out  1  high while `reg_out`/counts hold a completed packet.
- `pkt_done`  out  1  one-cycle pulse when a packet completes.
- `beat_count`  out  16  beats in the last/current packet, saturating at 16'hFFFF.
- `byte_count`  out  32  bytes in the last completed packet.
- `pkt_count`  out  16  completed packets, wraps.
- `err_sop`  out  1  sticky: sop received while a packet was open.
- `err_orphan`  out  1  sticky: beat received with no packet open and no sop.
- `overflow`  out  1  sticky: packet exceeded DEPTH beats.

## Operation
- States: IDLE (no open packet) and BUSY (packet open). Reset → IDLE.
- Accepted sop beat in any state: clear `reg_out` to 0, write `data` to `reg_out[0]`, set `beat_count` to 1, clear `pkt_valid`, go to BUSY. If it arrives in BUSY, also set `err_sop`; the old packet is abandoned, not counted.
- Accepted non-sop beat in BUSY: if `beat_count < DEPTH`, write `reg_out[beat_count]`; otherwise drop the data and set `overflow`. Increment `beat_count` (saturating).
- Accepted non-sop beat in IDLE: drop it and set `err_orphan`. No other state changes.
- Accepted eop beat (including a sop+eop single beat): `byte_count` = total beats × WIDTH/8 − `empty`, computed at 32-bit width. Set `pkt_valid`, pulse `pkt_done`, increment `pkt_count`, go to IDLE.
- Backpressure is generated by free-running logic, independent of `valid`.
  - Mode 1: counter counts 0..BP_PERIOD−1; `ready` is low when the counter equals BP_PERIOD−1.
  - Mode 2: 16-bit Fibonacci LFSR with taps 16,14,13,11, seed 16'hACE1, stepped every cycle; `ready = |lfsr[1:0]`.
- `clr` zeroes `err_sop`, `err_orphan`, `overflow` and `pkt_count`. If a beat is accepted in the same cycle, that beat's error/count update wins.
- `rst` clears every output and register. `reg_out`, counts and flags reset to 0, `pkt_valid` and `pkt_done` to 0, and any open packet is discarded. Whether `ready` is high in the first cycle after reset depends only on `bp_mode`; the counter and LFSR restart from 0 and the seed.

## Timing
- `ready` is a combinational decode of registered generator state plus `bp_mode`. It never depends on `valid`.
- Capture latency is 1 cycle: `reg_out`, `beat_count` and the flags update on the edge that accepts the beat.
- `pkt_done`, `pkt_valid`, `byte_count` and `pkt_count` are visible in the cycle after the eop beat is accepted.
- Back-to-back packets (eop beat immediately followed by sop beat) are sustained at full rate with no bubble.
- Beats presented while `ready` is low are not consumed and cause no state change.

## Structure
- Package `avalon_sink_pkg` holds:
  - the `state_t` enum (IDLE, BUSY);
  - the `bp_mode_t` enum;
  - the LFSR seed and tap constants.
- Sub-module `avalon_bp_gen` contains the periodic counter, the LFSR and the `ready` decode. The top level holds the framing FSM and capture bank.

## Test plan
- Mode 0, 3-beat packet A0/A1/A2, eop `empty`=3, DEPTH=4 → `reg_out` = {0, A2, A1, A0}, `byte_count`=21, `pkt_count`=1, one `pkt_done` pulse.
- Single beat with sop+eop and `empty`=0 → `beat_count`=1, `byte_count`=8, `reg_out[1..3]`=0.
- 6-beat packet, DEPTH=4 → `overflow`=1, `reg_out` holds beats 0–3, `beat_count`=6, `byte_count`=48.
- sop, one beat, then a second sop → `err_sop`=1, `pkt_count` unchanged until the second packet's eop. A beat with no sop from IDLE → `err_orphan`=1.
- Mode 1 with BP_PERIOD=5 and `valid` held high → `ready` low exactly every 5th cycle. Mode 2 → `ready` sequence matches a reference LFSR model from seed ACE1. A 10-beat packet is captured correctly under both modes.
- `rst` asserted mid-packet, then a clean packet → all outputs 0 after reset, and the new packet is captured with `pkt_count`=1.
